// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch front-end sequencer.
// Button event bit i of the event vector corresponds to PRIO_ORDER[i]; bit 0 wins.
package stopwatch_ctrl_pkg;

    localparam int BCD_W   = 16;
    localparam int NUM_BTN = 7;

    localparam logic [BCD_W-1:0] LIM_UP_BCD   = 16'h4030;
    localparam logic [BCD_W-1:0] LIM_DOWN_BCD = 16'h1020;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        CMD   = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {CMD_NONE, CMD_RST, CMD_ADD, CMD_SUB} cmd_e;

    typedef enum logic [2:0] {
        EV_NONE, EV_RST, EV_SS, EV_DIR, EV_ADD, EV_SUB, EV_FAST, EV_SLOW
    } evt_e;

    localparam evt_e PRIO_ORDER [NUM_BTN] =
        '{EV_RST, EV_SS, EV_DIR, EV_ADD, EV_SUB, EV_FAST, EV_SLOW};

    function automatic evt_e pick_winner(input logic [NUM_BTN-1:0] ev);
        pick_winner = EV_NONE;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (ev[i]) pick_winner = PRIO_ORDER[i];
        end
    endfunction

    function automatic cmd_e evt_to_cmd(input evt_e e);
        case (e)
            EV_RST:  evt_to_cmd = CMD_RST;
            EV_ADD:  evt_to_cmd = CMD_ADD;
            EV_SUB:  evt_to_cmd = CMD_SUB;
            default: evt_to_cmd = CMD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Control pins and live BCD count shared between the sequencer and the stopwatch.
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic             START;
    logic             REVERSE;
    logic             RESET;
    logic             ADD;
    logic             SUBTRACT;
    logic             SPEED_UP;
    logic             SPEED_DOWN;
    logic [BCD_W-1:0] Q_in;

    modport master (
        output START, REVERSE, RESET, ADD, SUBTRACT, SPEED_UP, SPEED_DOWN,
        input  Q_in
    );

    modport slave (
        input  START, REVERSE, RESET, ADD, SUBTRACT, SPEED_UP, SPEED_DOWN,
        output Q_in
    );

endinterface

// File: rtl/btn_sync_edge.sv
// Raw button synchronizer followed by a registered rising-edge detector.
// One-cycle pulse appears SYNC_STAGES+1 edges after the first edge sampling raw high.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic RESET_N,
    input  logic raw,
    output logic pulse
);

    // sh[SYNC_STAGES-1:0] is the synchronizer; the top two bits feed the edge detector.
    logic [SYNC_STAGES+1:0] sh;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            sh    <= '0;
            pulse <= 1'b0;
        end else begin
            sh    <= {sh[SYNC_STAGES:0], raw};
            pulse <= sh[SYNC_STAGES] & ~sh[SYNC_STAGES+1];
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button arbiter, run/pause/done FSM, fixed-width command pulses and one-deep pending slot.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int               SYNC_STAGES  = 2,
    parameter int               PULSE_CYCLES = 4,
    parameter logic [BCD_W-1:0] UP_LIMIT     = LIM_UP_BCD,
    parameter logic [BCD_W-1:0] DOWN_LIMIT   = LIM_DOWN_BCD
) (
    input  logic                    clk_in,
    input  logic                    RESET_N,
    input  logic                    btn_start_stop,
    input  logic                    btn_dir,
    input  logic                    btn_reset,
    input  logic                    btn_add,
    input  logic                    btn_sub,
    input  logic                    btn_fast,
    input  logic                    btn_slow,
    stopwatch_ctrl_if.master        sw,
    output logic [2:0]              state,
    output logic                    done,
    output logic                    busy
);

    localparam int              CNT_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_CYCLES - 1);

    logic [NUM_BTN-1:0] raw_btn, ev;
    evt_e               win;
    cmd_e               win_cmd, pend_m;
    logic               terminal, enter_cmd, pulse_on;

    state_e             state_q, state_d, ret_q, ret_d;
    cmd_e               cmd_q, cmd_d, pend_q, pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gap_q, gap_d, rev_q, rev_d, up_q, up_d, dn_q, dn_d;

    assign raw_btn = {btn_slow, btn_fast, btn_sub, btn_add, btn_dir, btn_start_stop, btn_reset};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
            .clk_in (clk_in),
            .RESET_N(RESET_N),
            .raw    (raw_btn[i]),
            .pulse  (ev[i])
        );
    end

    assign win      = pick_winner(ev);
    assign win_cmd  = evt_to_cmd(win);
    assign terminal = (sw.Q_in == (rev_q ? DOWN_LIMIT : UP_LIMIT));

    function automatic logic cmd_legal(input state_e st, input cmd_e c);
        case (st)
            IDLE, PAUSE: cmd_legal = (c != CMD_NONE);
            RUN, DONE:   cmd_legal = (c == CMD_RST);
            default:     cmd_legal = 1'b0;
        endcase
    endfunction

    // A reset overwrites anything pending; add/sub only fill an empty slot.
    always_comb begin
        pend_m = pend_q;
        if (win_cmd == CMD_RST)
            pend_m = CMD_RST;
        else if (win_cmd != CMD_NONE && pend_q == CMD_NONE)
            pend_m = win_cmd;
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cmd_d     = cmd_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rev_d     = rev_q;
        up_d      = up_q;
        dn_d      = dn_q;
        enter_cmd = 1'b0;

        if (win == EV_FAST) begin
            up_d = ~up_q;
            dn_d = 1'b0;
        end else if (win == EV_SLOW) begin
            dn_d = ~dn_q;
            up_d = 1'b0;
        end

        case (state_q)
            IDLE, PAUSE: begin
                if (win == EV_SS)              state_d = RUN;
                else if (win == EV_DIR)        rev_d = ~rev_q;
                else if (win_cmd != CMD_NONE)  enter_cmd = 1'b1;
            end
            RUN: begin
                if (win == EV_RST)      enter_cmd = 1'b1;
                else if (terminal)      state_d = DONE;
                else if (win == EV_SS)  state_d = PAUSE;
            end
            DONE: begin
                if (win == EV_RST) begin
                    enter_cmd = 1'b1;
                end else if (win == EV_DIR) begin
                    rev_d   = ~rev_q;
                    state_d = PAUSE;
                end
            end
            CMD: begin
                pend_d = pend_m;
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cmd_legal(ret_q, pend_m)) begin
                    // Chain the pending command after one all-low cycle.
                    cmd_d  = pend_m;
                    pend_d = CMD_NONE;
                    gap_d  = 1'b1;
                    cnt_d  = '0;
                    if (pend_m == CMD_RST) ret_d = IDLE;
                end else begin
                    state_d = ret_q;
                    cmd_d   = CMD_NONE;
                    pend_d  = CMD_NONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_cmd) begin
            state_d = CMD;
            cmd_d   = win_cmd;
            cnt_d   = '0;
            gap_d   = 1'b0;
            pend_d  = CMD_NONE;
            ret_d   = (win_cmd == CMD_RST) ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk_in or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            cmd_q   <= CMD_NONE;
            pend_q  <= CMD_NONE;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            rev_q   <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            cmd_q   <= cmd_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rev_q   <= rev_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    // Pulses decode from registered state, so an async reset cuts them off at once.
    assign pulse_on      = (state_q == CMD) && !gap_q;
    assign sw.START      = (state_q == RUN);
    assign sw.REVERSE    = rev_q;
    assign sw.RESET      = pulse_on && (cmd_q == CMD_RST);
    assign sw.ADD        = pulse_on && (cmd_q == CMD_ADD);
    assign sw.SUBTRACT   = pulse_on && (cmd_q == CMD_SUB);
    assign sw.SPEED_UP   = up_q;
    assign sw.SPEED_DOWN = dn_q;

    assign state = state_q;
    assign done  = (state_q == DONE);
    assign busy  = (state_q == CMD);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (SYNC_STAGES=2, PULSE_CYCLES=4).
module tb_stopwatch_ctrl;

    localparam int B_RST = 0, B_SS = 1, B_DIR = 2, B_ADD = 3, B_SUB = 4, B_FAST = 5, B_SLOW = 6;
    localparam int S_ADD = 0, S_SUB = 1, S_RST = 2;

    logic       clk;
    logic       rst_n;
    logic [6:0] b;
    logic [2:0] state;
    logic       done, busy;
    int         total, bad, both_cnt;

    stopwatch_ctrl_if sw();

    stopwatch_ctrl #(.SYNC_STAGES(2), .PULSE_CYCLES(4)) dut (
        .clk_in        (clk),
        .RESET_N       (rst_n),
        .btn_start_stop(b[B_SS]),
        .btn_dir       (b[B_DIR]),
        .btn_reset     (b[B_RST]),
        .btn_add       (b[B_ADD]),
        .btn_sub       (b[B_SUB]),
        .btn_fast      (b[B_FAST]),
        .btn_slow      (b[B_SLOW]),
        .sw            (sw),
        .state         (state),
        .done          (done),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (sw.SPEED_UP && sw.SPEED_DOWN) both_cnt <= both_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raw press held for two sampling edges; caller is left just after the second.
    task automatic press(input int idx);
        b[idx] = 1'b1;
        tick(2);
        b[idx] = 1'b0;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_ADD:   return sw.ADD;
            S_SUB:   return sw.SUBTRACT;
            S_RST:   return sw.RESET;
            default: return 1'b0;
        endcase
    endfunction

    task automatic count_high(input int sel, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sig(sel)) n++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, sw.START, 0);
        check({tag, "_rev"},   sw.REVERSE, 0);
        check({tag, "_rst"},   sw.RESET, 0);
        check({tag, "_add"},   sw.ADD, 0);
        check({tag, "_sub"},   sw.SUBTRACT, 0);
        check({tag, "_up"},    sw.SPEED_UP, 0);
        check({tag, "_dn"},    sw.SPEED_DOWN, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        int n, n_add, n_sub, n_rst, last_add, first_rst;
        total = 0; bad = 0; both_cnt = 0;
        rst_n = 1'b0; b = '0; sw.Q_in = 16'h0000;
        tick(2);
        check_all_zero("por");
        rst_n = 1'b1;
        tick(2);

        // 1: start press; START rises on the 4th edge after the sampling edge
        b[B_SS] = 1'b1;
        tick(1);
        tick(1); b[B_SS] = 1'b0;
        tick(2);
        check("t1_start_e3", sw.START, 0);
        tick(1);
        check("t1_start_e4", sw.START, 1);
        check("t1_state", state, 1);

        // 2: terminal count up, start/stop ignored in DONE
        sw.Q_in = 16'h4029;
        tick(3);
        check("t2_no_term", sw.START, 1);
        sw.Q_in = 16'h4030;
        tick(1);
        check("t2_start", sw.START, 0);
        check("t2_done", done, 1);
        check("t2_state", state, 4);
        sw.Q_in = 16'h0000;
        press(B_SS); tick(3);
        check("t2_ss_ign", sw.START, 0);
        check("t2_ss_state", state, 4);
        press(B_DIR); tick(3);
        check("t2_dir_state", state, 2);
        check("t2_dir_rev", sw.REVERSE, 1);

        // 3a: add then dir one cycle later; dir lands in CMD and is dropped
        b[B_ADD] = 1'b1; tick(1);
        b[B_DIR] = 1'b1; tick(2);
        b = '0;
        count_high(S_ADD, 12, n);
        check("t3a_add_w", n, 4);
        check("t3a_rev", sw.REVERSE, 1);
        check("t3a_state", state, 2);
        check("t3a_busy", busy, 0);

        // 3b: add and dir in the same cycle; dir outranks add
        b[B_ADD] = 1'b1; b[B_DIR] = 1'b1;
        tick(2);
        b = '0;
        count_high(S_ADD, 12, n);
        check("t3b_add_w", n, 0);
        check("t3b_rev", sw.REVERSE, 0);
        check("t3b_state", state, 2);

        // 4: sub then reset arrive during ADD; reset replaces sub in the slot
        b[B_ADD] = 1'b1; tick(1);
        b[B_SUB] = 1'b1; tick(1);
        b[B_RST] = 1'b1; tick(2);
        b = '0;
        n_add = 0; n_sub = 0; n_rst = 0; last_add = -1; first_rst = -1;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (sw.ADD) begin n_add++; last_add = i; end
            if (sw.SUBTRACT) n_sub++;
            if (sw.RESET) begin n_rst++; if (first_rst < 0) first_rst = i; end
        end
        check("t4_add_w", n_add, 4);
        check("t4_rst_w", n_rst, 4);
        check("t4_sub_w", n_sub, 0);
        check("t4_gap", first_rst - last_add - 1, 1);
        check("t4_state", state, 0);
        check("t4_busy", busy, 0);

        // 5: dir/add ignored while running; speed toggles stay exclusive
        press(B_SS); tick(3);
        check("t5_run", state, 1);
        press(B_DIR); tick(3);
        press(B_ADD);
        count_high(S_ADD, 6, n);
        check("t5_add_ign", n, 0);
        check("t5_rev", sw.REVERSE, 0);
        check("t5_start", sw.START, 1);
        press(B_FAST); tick(3);
        check("t5_up1", sw.SPEED_UP, 1);
        press(B_FAST); tick(3);
        check("t5_up0", sw.SPEED_UP, 0);
        press(B_SLOW); tick(3);
        check("t5_dn1", sw.SPEED_DOWN, 1);
        check("t5_up_after_slow", sw.SPEED_UP, 0);
        press(B_FAST); tick(3);
        check("t5_up_clr_dn", {sw.SPEED_UP, sw.SPEED_DOWN}, 2'b10);
        check("t5_excl", both_cnt, 0);
        check("t5_still_run", state, 1);

        // 6: async reset mid-RESET pulse with an add pending
        press(B_SS); tick(3);
        check("t6_pause", state, 2);
        b[B_RST] = 1'b1; tick(1);
        b[B_ADD] = 1'b1; tick(3);
        b = '0;
        tick(3);
        check("t6_rst_on", sw.RESET, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_async");
        tick(2);
        rst_n = 1'b1;
        count_high(S_ADD, 20, n);
        check("t6_no_stale", n, 0);
        check("t6_state", state, 0);
        check("t6_busy", busy, 0);

        // 7: counting down terminates on the down limit only
        press(B_DIR); tick(3);
        check("t7_rev", sw.REVERSE, 1);
        press(B_SS); tick(3);
        sw.Q_in = 16'h4030;
        tick(3);
        check("t7_up_lim_ign", state, 1);
        sw.Q_in = 16'h1020;
        tick(1);
        check("t7_down_term", state, 4);
        check("t7_start", sw.START, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
